bsg_mem_2r1w_sync_reader: RTL
=============================

// Module: bsg_mem_2r1w_sync_reader
// PURPOSE
//  Read-side client for a 2r1w synchronous-read memory. Takes dual-address read
//  requests on a valid/ready handshake, drives the memory's r0/r1 ports, and
//  returns both read words on a valid/yumi handshake.
//  Handles the memory's 1-cycle read latency with a 2-entry response buffer.
//  Resolves same-cycle read/write address collisions, which the memory forbids
//  (read_write_same_addr_p=0), by snooping the write port.
// PARAMETERS
//  width_p        -1                   data width in bits (must be set)
//  els_p          -1                   memory depth (must be set)
//  addr_width_lp  `BSG_SAFE_CLOG2(els_p) address width (derived, not to be overridden)
// PORTS
//  clk_i        in   1              clock; all state changes on posedge
//  reset_i      in   1              synchronous, active-high reset
//  v_i          in   1              read request valid
//  ready_o      out  1              request accepted when v_i & ready_o
//  r0_addr_i    in   addr_width_lp  request address, port 0
//  r1_addr_i    in   addr_width_lp  request address, port 1
//  v_o          out  1              response valid
//  r0_data_o    out  width_p        response word, port 0
//  r1_data_o    out  width_p        response word, port 1
//  yumi_i       in   1              consumer takes the response; legal only when v_o=1
//  w_v_i        in   1              snooped memory write valid
//  w_addr_i     in   addr_width_lp  snooped memory write address
//  w_data_i     in   width_p        snooped memory write data
//  mem_r0_v_o   out  1              to memory r0_v_i
//  mem_r0_addr_o out addr_width_lp  to memory r0_addr_i
//  mem_r0_data_i in  width_p        from memory r0_data_o (valid cycle after read)
//  mem_r1_v_o, mem_r1_addr_o, mem_r1_data_i: same as r0, for port 1
// BEHAVIOUR
//  - Reset: count_r=0, in-flight flag=0, FIFO empty, forward flags=0.
//    Outputs in and after reset: v_o=0, mem_r*_v_o=0, ready_o=1 from the first
//    cycle after reset deasserts. An in-flight read at reset is dropped; no
//    response is produced for it.
//  - Accept: acc = v_i & ready_o. On acc, mem_rX_addr_o = rX_addr_i and
//    mem_rX_v_o = 1, except when forwarding suppresses that port (see below).
//  - count_r: accepted-but-not-yumied responses, range 0..2.
//    +1 on acc, -1 on yumi_i. acc & yumi_i in the same cycle leaves it unchanged.
//  - ready_o = (count_r < 2), ANDed with the collision term when FWD is disabled.
//    At count_r=2 a further request is held off even if yumi_i=1 that cycle.
//  - Latency: request accepted in cycle N gives its response visible in N+1,
//    earliest. If the FIFO is empty in N+1, v_o=1 and data comes combinationally
//    from mem_rX_data_i or the forward register. If that response is not yumied
//    in N+1, it is written into the FIFO.
//  - FIFO: 2 entries, in order. Whenever the FIFO is non-empty, the head drives
//    the outputs and a newly arriving response is enqueued behind it.
//    The FIFO cannot overflow because count_r is limited to 2.
//  - Collision: port X collides when acc & w_v_i & (w_addr_i == rX_addr_i),
//    evaluated per port. Both ports may collide in the same cycle.
//  - A write in N+1 to an address read in N is not a collision. The response
//    carries the pre-write value.
//  - v_o / data_o stay stable while v_o=1 & ~yumi_i.
// CONFIGURATION
//  BSG_MEM_2R1W_SYNC_READER_FWD_EN
//   defined:   a colliding port is accepted. Its mem_rX_v_o is forced to 0;
//              fwdX_r<=1 and fwd_dataX_r<=w_data_i. In N+1 that port's response
//              word is fwd_dataX_r.
//   undefined: ready_o = (count_r<2) & ~(w_v_i & ((w_addr_i==r0_addr_i) |
//              (w_addr_i==r1_addr_i))). The request stalls until no collision.
//              ready_o is then combinational on v_i-independent inputs only.
//  In both modes, the memory never sees a same-address read and write.
// TESTING
//  1 Write mem[5]=0xA5A5, mem[9]=0x1234; request (5,9) with yumi_i=1 held
//    -> v_o=1 the next cycle with r0=0xA5A5, r1=0x1234; count_r returns to 0.
//  2 yumi_i=0; issue 3 back-to-back requests
//    -> ready_o=0 on the 3rd; two responses returned in order once yumi_i asserts.
//  3 Request (7,7) with w_v_i=1, w_addr_i=7, w_data_i=0xBEEF in the same cycle.
//    FWD_EN: accepted, mem_r*_v_o=0, response 0xBEEF/0xBEEF.
//    No FWD_EN: ready_o=0 that cycle; accepted the next cycle; response 0xBEEF.
//  4 Request addr 3 (old 0x11) in N, write addr 3=0x22 in N+1
//    -> response 0x11; no assertion fires.
//  5 Accept a request, then assert reset_i in N+1
//    -> v_o=0 during and after reset; no stale response; ready_o=1 after reset.
//  6 Random v_i/yumi_i/w_* for 10k cycles against a scoreboard model
//    -> every response matches; count_r never exceeds 2; no same-address
//       read/write reaches the memory.

Source files
------------

// File: rtl/bsg_mem_2r1w_sync_reader.sv
// rtl/bsg_mem_2r1w_sync_reader.sv - read-side client for a 2r1w sync-read memory with a 2-entry response buffer
// Optional write-to-read forwarding on collisions: BSG_MEM_2R1W_SYNC_READER_FWD_EN
module bsg_mem_2r1w_sync_reader #(
    parameter int width_p       = -1,
    parameter int els_p         = -1,
    parameter int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,

    output logic                     v_o,
    output logic [width_p-1:0]       r0_data_o,
    output logic [width_p-1:0]       r1_data_o,
    input  logic                     yumi_i,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,

    output logic                     mem_r0_v_o,
    output logic [addr_width_lp-1:0] mem_r0_addr_o,
    input  logic [width_p-1:0]       mem_r0_data_i,
    output logic                     mem_r1_v_o,
    output logic [addr_width_lp-1:0] mem_r1_addr_o,
    input  logic [width_p-1:0]       mem_r1_data_i
);

    logic [1:0]         count_r;
    logic               inflight_r;

    logic [width_p-1:0] fifo_d0_r [2];
    logic [width_p-1:0] fifo_d1_r [2];
    logic               fifo_head_r;
    logic               fifo_tail_r;
    logic [1:0]         fifo_count_r;

    logic               acc;
    logic               col0;
    logic               col1;
    logic               fifo_empty;
    logic               enq;
    logic               deq;
    logic               yumi_v;
    logic [width_p-1:0] resp_d0;
    logic [width_p-1:0] resp_d1;

`ifdef BSG_MEM_2R1W_SYNC_READER_FWD_EN
    logic               fwd0_r;
    logic               fwd1_r;
    logic [width_p-1:0] fwd_data0_r;
    logic [width_p-1:0] fwd_data1_r;

    assign ready_o = ~reset_i & (count_r != 2'd2);
    assign resp_d0 = fwd0_r ? fwd_data0_r : mem_r0_data_i;
    assign resp_d1 = fwd1_r ? fwd_data1_r : mem_r1_data_i;
`else
    logic               col_any;

    // Stall rather than forward: a colliding request is never accepted.
    assign col_any = w_v_i & ((w_addr_i == r0_addr_i) | (w_addr_i == r1_addr_i));
    assign ready_o = ~reset_i & (count_r != 2'd2) & ~col_any;
    assign resp_d0 = mem_r0_data_i;
    assign resp_d1 = mem_r1_data_i;
`endif

    assign acc  = v_i & ready_o;
    assign col0 = acc & w_v_i & (w_addr_i == r0_addr_i);
    assign col1 = acc & w_v_i & (w_addr_i == r1_addr_i);

    assign mem_r0_v_o    = acc & ~col0;
    assign mem_r1_v_o    = acc & ~col1;
    assign mem_r0_addr_o = r0_addr_i;
    assign mem_r1_addr_o = r1_addr_i;

    // The buffer head takes priority; an empty buffer lets the fresh word bypass.
    assign fifo_empty = (fifo_count_r == 2'd0);
    assign v_o        = ~reset_i & (~fifo_empty | inflight_r);
    assign r0_data_o  = fifo_empty ? resp_d0 : fifo_d0_r[fifo_head_r];
    assign r1_data_o  = fifo_empty ? resp_d1 : fifo_d1_r[fifo_head_r];

    assign yumi_v = yumi_i & v_o;
    assign deq    = yumi_v & ~fifo_empty;
    assign enq    = inflight_r & (~fifo_empty | ~yumi_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r      <= 2'd0;
            inflight_r   <= 1'b0;
            fifo_head_r  <= 1'b0;
            fifo_tail_r  <= 1'b0;
            fifo_count_r <= 2'd0;
        end else begin
            count_r      <= count_r + {1'b0, acc} - {1'b0, yumi_v};
            inflight_r   <= acc;
            fifo_count_r <= fifo_count_r + {1'b0, enq} - {1'b0, deq};
            if (enq) begin
                fifo_tail_r <= ~fifo_tail_r;
            end
            if (deq) begin
                fifo_head_r <= ~fifo_head_r;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_d0_r[fifo_tail_r] <= resp_d0;
            fifo_d1_r[fifo_tail_r] <= resp_d1;
        end
    end

`ifdef BSG_MEM_2R1W_SYNC_READER_FWD_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd0_r <= 1'b0;
            fwd1_r <= 1'b0;
        end else begin
            fwd0_r <= col0;
            fwd1_r <= col1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (col0) begin
            fwd_data0_r <= w_data_i;
        end
        if (col1) begin
            fwd_data1_r <= w_data_i;
        end
    end
`endif

endmodule
